// File: rtl/fpadd_pkg.sv
// Shared types and constants for the FP adder arbiter slice.
package fpadd_pkg;

    // Default core latency from issue to result.
    localparam int FPADD_LATENCY = 4;

    // One IEEE-754 single-precision word.
    typedef logic [31:0] fp32_t;

    // Drain sequencer states.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        EMPTY = 2'd2
    } arb_state_e;

    // Ownership tag that travels alongside each in-flight operation.
    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

endpackage

// File: rtl/fpadd_tag_pipe.sv
// Ownership tag shift register running in lock-step with the FP adder core.
// The tail stage lines up with the core result; any_valid_o reports whether
// any tag (including the one entering now) is still in flight beyond the tail.
module fpadd_tag_pipe
    import fpadd_pkg::*;
#(
    parameter int DEPTH = FPADD_LATENCY
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t tag_i,
    output tag_t tail_o,
    output logic any_valid_o
);

    tag_t stage_q [DEPTH];

    // Shift tags one stage per cycle; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tail_o = stage_q[DEPTH-1];

    // Occupancy excluding the tail: the tail's result is delivered this
    // cycle, so the pipe is empty from the next cycle on when this is low.
    always_comb begin
        any_valid_o = tag_i.valid;
        for (int i = 0; i < DEPTH - 1; i++) begin
            any_valid_o = any_valid_o | stage_q[i].valid;
        end
    end

endmodule

// File: rtl/fpadd_arbiter.sv
// Two-requester issue arbiter for a shared fixed-latency FP adder core.
// Accepts operand pairs via valid/ready, issues one pair per cycle, tracks
// ownership of each in-flight op and steers results back to their owner.
// A drain sequencer stops issue and flags when the core is empty.
// Build option: FPADD_ARB_RR_EN selects round-robin tie breaking; without
// it requester 0 always wins ties.
module fpadd_arbiter
    import fpadd_pkg::*;
#(
    parameter int LATENCY = FPADD_LATENCY,
    parameter int NREQ    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0][31:0] req_a,
    input  logic [NREQ-1:0][31:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  core_valid,
    output logic [31:0]           core_a,
    output logic [31:0]           core_b,
    input  logic [31:0]           core_sum,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [31:0]           rsp_sum,
    input  logic                  drain_req,
    output logic                  drain_done
);

    arb_state_e state_q, state_d;

    logic       core_valid_q, core_valid_d;
    logic       core_id_q, core_id_d;
    fp32_t      core_a_q, core_a_d;
    fp32_t      core_b_q, core_b_d;

    logic [1:0] grant_s;
    logic       win_id_s;
    logic       transfer_s;

    tag_t       issue_tag_s;
    tag_t       tail_tag_s;
    logic       any_valid_s;

`ifdef FPADD_ARB_RR_EN
    logic       last_grant_q, last_grant_d;
`endif

    // Grant selection: only while running; ties broken by pointer or priority.
    always_comb begin
        grant_s  = 2'b00;
        win_id_s = 1'b0;
        if (state_q == RUN) begin
            case (req_valid)
                2'b01: begin
                    grant_s  = 2'b01;
                    win_id_s = 1'b0;
                end
                2'b10: begin
                    grant_s  = 2'b10;
                    win_id_s = 1'b1;
                end
                2'b11: begin
`ifdef FPADD_ARB_RR_EN
                    if (last_grant_q) begin
                        grant_s  = 2'b01;
                        win_id_s = 1'b0;
                    end else begin
                        grant_s  = 2'b10;
                        win_id_s = 1'b1;
                    end
`else
                    grant_s  = 2'b01;
                    win_id_s = 1'b0;
`endif
                end
                default: begin
                    grant_s  = 2'b00;
                    win_id_s = 1'b0;
                end
            endcase
        end else begin
            grant_s  = 2'b00;
            win_id_s = 1'b0;
        end
    end

    assign req_ready  = grant_s;
    assign transfer_s = |(req_valid & grant_s);

    // Issue-stage next state: capture the winner's operands on a transfer.
    always_comb begin
        core_valid_d = transfer_s;
        core_id_d    = core_id_q;
        core_a_d     = core_a_q;
        core_b_d     = core_b_q;
        if (transfer_s) begin
            core_id_d = win_id_s;
            core_a_d  = req_a[win_id_s];
            core_b_d  = req_b[win_id_s];
        end else begin
            core_id_d = core_id_q;
            core_a_d  = core_a_q;
            core_b_d  = core_b_q;
        end
    end

    // Issue-stage registers driving the core.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_valid_q <= 1'b0;
            core_id_q    <= 1'b0;
            core_a_q     <= 32'h0000_0000;
            core_b_q     <= 32'h0000_0000;
        end else begin
            core_valid_q <= core_valid_d;
            core_id_q    <= core_id_d;
            core_a_q     <= core_a_d;
            core_b_q     <= core_b_d;
        end
    end

`ifdef FPADD_ARB_RR_EN
    // Pointer next state: moves only when a transfer actually happens.
    always_comb begin
        if (transfer_s) begin
            last_grant_d = win_id_s;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Round-robin pointer; resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign core_valid = core_valid_q;
    assign core_a     = core_a_q;
    assign core_b     = core_b_q;

    // The tag enters alongside the issued operands so its tail meets core_sum.
    always_comb begin
        issue_tag_s.valid = core_valid_q;
        issue_tag_s.id    = core_id_q;
    end

    fpadd_tag_pipe #(
        .DEPTH (LATENCY)
    ) u_tag_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .tag_i       (issue_tag_s),
        .tail_o      (tail_tag_s),
        .any_valid_o (any_valid_s)
    );

    // Result steering to the owner recorded in the tail tag.
    always_comb begin
        rsp_valid = 2'b00;
        if (tail_tag_s.valid) begin
            rsp_valid = tail_tag_s.id ? 2'b10 : 2'b01;
        end else begin
            rsp_valid = 2'b00;
        end
    end

    assign rsp_sum = core_sum;

    // Drain sequencer next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (drain_req) begin
                    state_d = DRAIN;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (!any_valid_s) begin
                    state_d = EMPTY;
                end else begin
                    state_d = DRAIN;
                end
            end
            EMPTY: begin
                if (!drain_req) begin
                    state_d = RUN;
                end else begin
                    state_d = EMPTY;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Drain sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign drain_done = (state_q == EMPTY);

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Directed self-checking bench for fpadd_arbiter (LATENCY=4 and LATENCY=1).
module tb_fpadd_arbiter;

`ifdef FPADD_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam int L = 4;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    // LATENCY=4 instance
    logic [1:0]       req_valid0;
    logic [1:0][31:0] req_a0, req_b0;
    logic [1:0]       req_ready0;
    logic             core_valid0;
    logic [31:0]      core_a0, core_b0, core_sum0;
    logic [1:0]       rsp_valid0;
    logic [31:0]      rsp_sum0;
    logic             drain_req0, drain_done0;
    logic [31:0]      cp0 [4];

    // LATENCY=1 instance
    logic [1:0]       req_valid1;
    logic [1:0][31:0] req_a1, req_b1;
    logic [1:0]       req_ready1;
    logic             core_valid1;
    logic [31:0]      core_a1, core_b1, core_sum1;
    logic [1:0]       rsp_valid1;
    logic [31:0]      rsp_sum1;
    logic             drain_req1, drain_done1;
    logic [31:0]      cp1;

    fpadd_arbiter #(.LATENCY(L), .NREQ(2)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid0), .req_a(req_a0), .req_b(req_b0), .req_ready(req_ready0),
        .core_valid(core_valid0), .core_a(core_a0), .core_b(core_b0), .core_sum(core_sum0),
        .rsp_valid(rsp_valid0), .rsp_sum(rsp_sum0),
        .drain_req(drain_req0), .drain_done(drain_done0)
    );

    fpadd_arbiter #(.LATENCY(1), .NREQ(2)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid1), .req_a(req_a1), .req_b(req_b1), .req_ready(req_ready1),
        .core_valid(core_valid1), .core_a(core_a1), .core_b(core_b1), .core_sum(core_sum1),
        .rsp_valid(rsp_valid1), .rsp_sum(rsp_sum1),
        .drain_req(drain_req1), .drain_done(drain_done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in adder result: exact for the 1.0+2.0 vector, a tagged token otherwise.
    function automatic logic [31:0] core_fn(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a + b;
    endfunction

    // Fixed-latency core models.
    always @(posedge clk) begin
        cp0[0] <= core_fn(core_a0, core_b0);
        for (int k = 1; k < 4; k++) cp0[k] <= cp0[k-1];
        cp1 <= core_fn(core_a1, core_b1);
    end
    assign core_sum0 = cp0[3];
    assign core_sum1 = cp1;

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid0 = 2'b00; req_a0 = '0; req_b0 = '0; drain_req0 = 1'b0;
        req_valid1 = 2'b00; req_a1 = '0; req_b1 = '0; drain_req1 = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (req_ready0 !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", req_ready0); end
        checks++; if (core_valid0 !== 1'b0) begin errors++; $display("FAIL reset_core_valid got=%b exp=0", core_valid0); end
        checks++; if (core_a0 !== 32'h0) begin errors++; $display("FAIL reset_core_a got=%h exp=0", core_a0); end
        checks++; if (core_b0 !== 32'h0) begin errors++; $display("FAIL reset_core_b got=%h exp=0", core_b0); end
        checks++; if (rsp_valid0 !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid0); end
        checks++; if (drain_done0 !== 1'b0) begin errors++; $display("FAIL reset_drain_done got=%b exp=0", drain_done0); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (core_valid0 !== 1'b0) begin errors++; $display("FAIL post_reset_core_valid got=%b exp=0", core_valid0); end
    endtask

    task automatic test_contention();
        logic [31:0] ea [6];
        logic [31:0] eb [6];
        logic [31:0] es [6];
        logic        eid [6];
        logic        exp_last;
        logic        win;
        exp_last = 1'b1;
        for (int t = 0; t <= 6 + L + 1; t++) begin
            @(negedge clk);
            if (t >= 1 && t <= 6) begin
                checks++; if (core_valid0 !== 1'b1) begin errors++; $display("FAIL cont_core_valid t=%0d got=%b exp=1", t, core_valid0); end
                checks++; if (core_a0 !== ea[t-1]) begin errors++; $display("FAIL cont_core_a t=%0d got=%h exp=%h", t, core_a0, ea[t-1]); end
                checks++; if (core_b0 !== eb[t-1]) begin errors++; $display("FAIL cont_core_b t=%0d got=%h exp=%h", t, core_b0, eb[t-1]); end
            end
            if (t >= L + 1 && t <= L + 6) begin
                checks++; if (rsp_valid0 !== (eid[t-L-1] ? 2'b10 : 2'b01)) begin errors++; $display("FAIL cont_rsp_valid t=%0d got=%b owner=%0d", t, rsp_valid0, eid[t-L-1]); end
                checks++; if (rsp_sum0 !== es[t-L-1]) begin errors++; $display("FAIL cont_rsp_sum t=%0d got=%h exp=%h", t, rsp_sum0, es[t-L-1]); end
            end else begin
                checks++; if (rsp_valid0 !== 2'b00) begin errors++; $display("FAIL cont_rsp_idle t=%0d got=%b exp=00", t, rsp_valid0); end
            end
            if (t < 6) begin
                req_valid0 = 2'b11;
                req_a0[0] = 32'h1000_0000 + 32'(t); req_b0[0] = 32'h0000_1000 + 32'(t);
                req_a0[1] = 32'h2000_0000 + 32'(t); req_b0[1] = 32'h0000_2000 + 32'(t);
                win = RR ? ~exp_last : 1'b0;
                exp_last = win;
                eid[t] = win;
                ea[t] = win ? req_a0[1] : req_a0[0];
                eb[t] = win ? req_b0[1] : req_b0[0];
                es[t] = core_fn(ea[t], eb[t]);
                #1;
                checks++; if (req_ready0 !== (win ? 2'b10 : 2'b01)) begin errors++; $display("FAIL cont_grant t=%0d got=%b exp_id=%0d", t, req_ready0, win); end
            end else begin
                req_valid0 = 2'b00;
            end
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        req_valid0 = 2'b01; req_a0[0] = 32'h3F80_0000; req_b0[0] = 32'h4000_0000;
        #1;
        checks++; if (req_ready0 !== 2'b01) begin errors++; $display("FAIL single_ready got=%b exp=01", req_ready0); end
        for (int k = 1; k <= L + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++; if (core_valid0 !== 1'b1) begin errors++; $display("FAIL single_core_valid got=%b exp=1", core_valid0); end
                checks++; if (core_a0 !== 32'h3F80_0000) begin errors++; $display("FAIL single_core_a got=%h exp=3f800000", core_a0); end
                checks++; if (core_b0 !== 32'h4000_0000) begin errors++; $display("FAIL single_core_b got=%h exp=40000000", core_b0); end
                req_valid0 = 2'b00;
            end
            if (k == 2) begin
                checks++; if (core_valid0 !== 1'b0) begin errors++; $display("FAIL single_idle_valid got=%b exp=0", core_valid0); end
                checks++; if (core_a0 !== 32'h3F80_0000) begin errors++; $display("FAIL single_hold_a got=%h exp=3f800000", core_a0); end
            end
            if (k <= L) begin
                checks++; if (rsp_valid0 !== 2'b00) begin errors++; $display("FAIL single_early_rsp k=%0d got=%b exp=00", k, rsp_valid0); end
            end else begin
                checks++; if (rsp_valid0 !== 2'b01) begin errors++; $display("FAIL single_rsp_valid got=%b exp=01", rsp_valid0); end
                checks++; if (rsp_sum0 !== 32'h4040_0000) begin errors++; $display("FAIL single_rsp_sum got=%h exp=40400000", rsp_sum0); end
            end
        end
    endtask

    task automatic test_drain();
        for (int t = 0; t <= 12; t++) begin
            @(negedge clk);
            if (t >= 1) begin
                checks++; if (core_valid0 !== (t <= 3 || t == 12)) begin errors++; $display("FAIL drain_core_valid t=%0d got=%b", t, core_valid0); end
                checks++; if (drain_done0 !== (t >= 8 && t <= 10)) begin errors++; $display("FAIL drain_done t=%0d got=%b", t, drain_done0); end
                checks++; if (rsp_valid0 !== ((t >= 5 && t <= 7) ? 2'b10 : 2'b00)) begin errors++; $display("FAIL drain_rsp_valid t=%0d got=%b", t, rsp_valid0); end
            end
            if (t >= 5 && t <= 7) begin
                checks++; if (rsp_sum0 !== core_fn(32'h5000_0000 + 32'(t - 5), 32'h0000_0077)) begin errors++; $display("FAIL drain_rsp_sum t=%0d got=%h", t, rsp_sum0); end
            end
            if (t == 12) begin
                checks++; if (core_a0 !== 32'h5000_000B) begin errors++; $display("FAIL drain_resume_a got=%h exp=5000000b", core_a0); end
            end
            req_a1[0] = 32'h0; req_a0[1] = 32'h5000_0000 + 32'(t); req_b0[1] = 32'h0000_0077;
            if (t <= 2) req_valid0 = 2'b10;
            else if (t == 3) begin req_valid0 = 2'b00; drain_req0 = 1'b1; end
            else if (t <= 11) req_valid0 = 2'b10;
            else req_valid0 = 2'b00;
            if (t == 10) drain_req0 = 1'b0;
            #1;
            if (t <= 2 || t == 11) begin
                checks++; if (req_ready0 !== 2'b10) begin errors++; $display("FAIL drain_ready_run t=%0d got=%b exp=10", t, req_ready0); end
            end else if (t >= 4 && t <= 10) begin
                checks++; if (req_ready0 !== 2'b00) begin errors++; $display("FAIL drain_ready_blocked t=%0d got=%b exp=00", t, req_ready0); end
            end
        end
        repeat (L + 2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        for (int t = 0; t <= 1; t++) begin
            @(negedge clk);
            req_valid0 = 2'b01; req_a0[0] = 32'h6000_0000 + 32'(t); req_b0[0] = 32'h0000_0001;
        end
        @(negedge clk);
        req_valid0 = 2'b00;
        rst_n = 1'b0;
        #1;
        checks++; if (req_ready0 !== 2'b00) begin errors++; $display("FAIL rmid_ready got=%b exp=00", req_ready0); end
        checks++; if (core_valid0 !== 1'b0) begin errors++; $display("FAIL rmid_core_valid got=%b exp=0", core_valid0); end
        checks++; if (core_a0 !== 32'h0) begin errors++; $display("FAIL rmid_core_a got=%h exp=0", core_a0); end
        checks++; if (core_b0 !== 32'h0) begin errors++; $display("FAIL rmid_core_b got=%h exp=0", core_b0); end
        checks++; if (rsp_valid0 !== 2'b00) begin errors++; $display("FAIL rmid_rsp_valid got=%b exp=00", rsp_valid0); end
        checks++; if (drain_done0 !== 1'b0) begin errors++; $display("FAIL rmid_drain_done got=%b exp=0", drain_done0); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 2 * L; k++) begin
            @(negedge clk);
            checks++; if (rsp_valid0 !== 2'b00) begin errors++; $display("FAIL rmid_ghost_rsp k=%0d got=%b exp=00", k, rsp_valid0); end
            checks++; if (core_valid0 !== 1'b0) begin errors++; $display("FAIL rmid_ghost_issue k=%0d got=%b exp=0", k, core_valid0); end
        end
    endtask

    task automatic test_lat1();
        logic [31:0] es [6];
        logic        eid [6];
        for (int t = 0; t <= 8; t++) begin
            @(negedge clk);
            if (t >= 2 && t <= 7) begin
                checks++; if (rsp_valid1 !== (eid[t-2] ? 2'b10 : 2'b01)) begin errors++; $display("FAIL lat1_rsp_valid t=%0d got=%b owner=%0d", t, rsp_valid1, eid[t-2]); end
                checks++; if (rsp_sum1 !== es[t-2]) begin errors++; $display("FAIL lat1_rsp_sum t=%0d got=%h exp=%h", t, rsp_sum1, es[t-2]); end
            end else begin
                checks++; if (rsp_valid1 !== 2'b00) begin errors++; $display("FAIL lat1_rsp_idle t=%0d got=%b exp=00", t, rsp_valid1); end
            end
            if (t < 6) begin
                eid[t] = t[0];
                req_valid1 = t[0] ? 2'b10 : 2'b01;
                req_a1[t[0]] = 32'h7000_0000 + 32'(t);
                req_b1[t[0]] = 32'h0000_0300 + 32'(t);
                es[t] = core_fn(32'h7000_0000 + 32'(t), 32'h0000_0300 + 32'(t));
                #1;
                checks++; if (req_ready1 !== (t[0] ? 2'b10 : 2'b01)) begin errors++; $display("FAIL lat1_ready t=%0d got=%b", t, req_ready1); end
            end else begin
                req_valid1 = 2'b00;
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_contention();
        test_single();
        test_drain();
        test_reset_mid();
        test_lat1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpadd_arbiter.md
# fpadd_arbiter

Round-robin arbiter and issue sequencer that shares one fixed-latency FP adder pipeline (unpack → alignment → add → normalize → round) between two requesters. It accepts operand pairs through valid/ready handshakes and issues at most one pair per cycle to the core. It tracks which requester owns each in-flight operation and steers each core result back to its owner. A drain FSM stops new issue and reports when the pipeline is empty, for mode changes and end-of-test.

## Interface
- LATENCY, 4: core cycles from issue (core_valid=1) to result on core_sum; range 1–16.
- NREQ, 2: number of requesters; fixed at 2 in this revision.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  [NREQ-1:0]  requester i presents an operand pair.
- req_a  in  [NREQ-1:0][31:0]  IEEE-754 single operand A per requester.
- req_b  in  [NREQ-1:0][31:0]  operand B per requester.
- req_ready  out  [NREQ-1:0]  one-hot or zero grant; transfer when valid&ready.
- core_valid  out  1  operand pair issued to the core this cycle.
- core_a, core_b  out  32 each  registered operands to the core.
- core_sum  in  32  core result; meaningful LATENCY cycles after issue.
- rsp_valid  out  [NREQ-1:0]  one-hot result strobe to the owner.
- rsp_sum  out  32  equals core_sum; qualified by rsp_valid.
- drain_req  in  1  level; request a stop to issue.
- drain_done  out  1  pipeline empty while draining.

## Operation
- FSM states are RUN, DRAIN and EMPTY. Reset enters RUN.
- RUN → DRAIN when drain_req=1.
- DRAIN → EMPTY when no tag in the tag pipe is valid.
- EMPTY → RUN when drain_req=0.
- EMPTY with drain_req=1 holds in EMPTY.
- req_ready is combinational and may be nonzero only in RUN.
- Grant rule, both requesters valid: ready goes to the requester that was not granted last (last_grant pointer).
- Grant rule, one requester valid: that requester is granted.
- The last_grant pointer updates only on an actual transfer.
- Transfer in cycle N: core_a/core_b capture the winner's operands and core_valid=1 in cycle N+1.
- Transfer in cycle N: tag {valid=1, id} enters stage 0 of a LATENCY-deep tag shift register.
- No transfer in cycle N: core_valid=0 in N+1 and core_a/core_b hold their previous values.
- Tag stage LATENCY-1 is valid with id i: rsp_valid[i]=1 in the same cycle.
- rsp_sum is a combinational pass-through of core_sum.
- Results have no backpressure. Owners must accept rsp_valid in the cycle it is asserted.
- drain_done=1 exactly while in EMPTY.
- drain_req asserted in the same cycle as a transfer: the transfer completes, and that operation is drained normally.

## Timing
- Reset values: req_ready=0, core_valid=0, core_a=0, core_b=0, rsp_valid=0, drain_done=0.
- Reset values (internal): all tags invalid, last_grant=1 so requester 0 wins the first tie.
- Issue latency: transfer in cycle N gives core_valid in N+1.
- Response latency: transfer in cycle N gives rsp_valid in N+1+LATENCY.
- Throughput: one transfer per cycle, sustained.
- Asserting reset mid-operation discards all in-flight tags. No rsp_valid is produced for them after reset releases.
- After drain_req rises, drain_done rises no later than LATENCY+2 cycles later.
- EMPTY → RUN: req_ready may assert in the cycle after drain_req falls.

## Configuration
- FPADD_ARB_RR_EN defined: round-robin grant as described above.
- FPADD_ARB_RR_EN undefined: fixed priority, requester 0 always wins ties, and last_grant is not implemented.
- All other behaviour is identical with or without the macro.

## Structure
- Shared package fpadd_pkg holds:
  - typedef fp32_t (32-bit word).
  - typedef arb_state_e {RUN, DRAIN, EMPTY}.
  - typedef tag_t {logic valid; logic id}.
  - Constant FPADD_LATENCY (default for LATENCY).
- One sub-module, fpadd_tag_pipe: a parameterised LATENCY-deep shift register of tag_t.
  - Outputs: the tail tag and an any-valid flag used by the drain FSM.

## Test plan
- Single request, LATENCY=4: req0 transfers a=0x3F800000, b=0x40000000 at cycle 10 → core_valid at 11 with those operands; core_sum driven 0x40400000 at 15 → rsp_valid=2'b01 and rsp_sum=0x40400000 at 15.
- Contention with FPADD_ARB_RR_EN: both requesters valid for 6 cycles → grants alternate 0,1,0,1,0,1; each response returns to its owner in issue order.
- Contention without the macro: both requesters valid for 4 cycles → all four grants go to requester 0; requester 1 waits with req_ready=0.
- Drain: 3 transfers back-to-back, then drain_req=1 → req_ready=0 immediately; drain_done=1 only after the third rsp_valid; drain_req=0 → RUN, and a new transfer is accepted the next cycle.
- Reset mid-flight: 2 transfers issued, rst_n low for 1 cycle → all outputs 0; no rsp_valid for 2·LATENCY cycles after release.
- LATENCY=1 sweep: continuous alternating requests → every result arrives 2 cycles after its transfer, with correct id.
